// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754-style add/subtract with a valid/ready stream.
// Stages: align (S1), add (S2), normalise and round (S3, output register).
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int SW = MAN_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W-1:0] DMAX = EXP_W'(M - 1);
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             vld;
    logic             spc;
    logic [W-1:0]     sres;
    logic [3:0]       sflg;
    logic             sx;
    logic             sub;
    logic [EXP_W-1:0] ex;
    logic [M-1:0]     mx;
    logic [M-1:0]     my;
  } s1_t;

  typedef struct packed {
    logic             vld;
    logic             spc;
    logic [W-1:0]     sres;
    logic [3:0]       sflg;
    logic             sx;
    logic [EXP_W-1:0] ex;
    logic [M:0]       sum;
  } s2_t;

  function automatic logic [EW-1:0] lzc(input logic [M-1:0] v);
    lzc = EW'(M);
    for (int i = 0; i < M; i++)
      if (v[i]) lzc = EW'(M - 1 - i);
  endfunction

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic         vld_d, vld_q;
  logic [W-1:0] res_d, res_q;
  logic [3:0]   flg_d, flg_q;
  logic         stall;

  assign stall     = vld_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_q;
  assign result    = res_q;
  assign flags     = flg_q;

  logic                   sa, sb, sy, swap;
  logic [EXP_W-1:0]       ea, eb, ey, d;
  logic [MAN_W-1:0]       fa, fb, fy;
  logic [EXP_W+MAN_W-1:0] mag_a, mag_b;
  logic                   a_nan, b_nan, a_inf, b_inf;
  logic                   a_zero, b_zero;
  logic [M-1:0]           ym, lost;

  always_comb begin
    sa     = A[W-1];
    sb     = B[W-1] ^ op;
    ea     = A[W-2:MAN_W];
    eb     = B[W-2:MAN_W];
    fa     = A[MAN_W-1:0];
    fb     = B[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_nan  = (ea == EMAX) & (fa != '0);
    b_nan  = (eb == EMAX) & (fb != '0);
    a_inf  = (ea == EMAX) & (fa == '0);
    b_inf  = (eb == EMAX) & (fb == '0);
    // denormals compare as zero
    mag_a  = a_zero ? '0 : A[W-2:0];
    mag_b  = b_zero ? '0 : B[W-2:0];
    swap   = mag_b > mag_a;
    sy     = swap ? sa : sb;
    ey     = swap ? ea : eb;
    fy     = swap ? fa : fb;

    s1_d      = '0;
    s1_d.vld  = in_valid;
    s1_d.sx   = swap ? sb : sa;
    s1_d.ex   = swap ? eb : ea;
    s1_d.mx   = {1'b1, swap ? fb : fa, 3'b000};
    s1_d.sub  = s1_d.sx ^ sy;

    ym   = (ey == '0) ? '0 : {1'b1, fy, 3'b000};
    d    = s1_d.ex - ey;
    lost = ym & ~({M{1'b1}} << d);
    if (d >= DMAX)
      s1_d.my = {{(M-1){1'b0}}, |ym};
    else
      s1_d.my = (ym >> d) | {{(M-1){1'b0}}, |lost};

    if (a_nan | b_nan | (a_inf & b_inf & (sa ^ sb))) begin
      s1_d.spc  = 1'b1;
      s1_d.sres = QNAN;
      s1_d.sflg = 4'b1000;
    end else if (a_inf) begin
      s1_d.spc  = 1'b1;
      s1_d.sres = {sa, EMAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      s1_d.spc  = 1'b1;
      s1_d.sres = {sb, EMAX, {MAN_W{1'b0}}};
    end else if (a_zero & b_zero) begin
      s1_d.spc  = 1'b1;
      s1_d.sres = {sa & sb, {(W-1){1'b0}}};
    end
  end

  always_comb begin
    s2_d      = '0;
    s2_d.vld  = s1_q.vld;
    s2_d.spc  = s1_q.spc;
    s2_d.sres = s1_q.sres;
    s2_d.sflg = s1_q.sflg;
    s2_d.sx   = s1_q.sx;
    s2_d.ex   = s1_q.ex;
    if (s1_q.sub)
      s2_d.sum = {1'b0, s1_q.mx} - {1'b0, s1_q.my};
    else
      s2_d.sum = {1'b0, s1_q.mx} + {1'b0, s1_q.my};
  end

  logic [EW-1:0]    lz, en, er;
  logic [M-1:0]     mn;
  logic [SW-1:0]    sig;
  logic [MAN_W-1:0] frac;
  logic             rup, inx, unf, ovf;

  always_comb begin
    lz = lzc(s2_q.sum[M-1:0]);
    if (s2_q.sum[M]) begin
      mn = {s2_q.sum[M:2], |s2_q.sum[1:0]};
      en = {2'b00, s2_q.ex} + EW'(1);
    end else begin
      mn = s2_q.sum[M-1:0] << lz;
      en = {2'b00, s2_q.ex} - lz;
    end
    rup  = mn[2] & (mn[3] | mn[1] | mn[0]);
    sig  = {1'b0, mn[M-1:3]} + SW'(rup);
    er   = en + EW'(sig[SW-1]);
    frac = sig[SW-1] ? sig[MAN_W:1] : sig[MAN_W-1:0];
    inx  = |mn[2:0];
    unf  = en[EW-1] | (en == '0);
    ovf  = ~unf & (er >= {2'b00, EMAX});

    vld_d = s2_q.vld;
    res_d = {s2_q.sx, er[EXP_W-1:0], frac};
    flg_d = {3'b000, inx};
    if (s2_q.spc) begin
      res_d = s2_q.sres;
      flg_d = s2_q.sflg;
    end else if (s2_q.sum == '0) begin
      res_d = '0;
      flg_d = '0;
    end else if (unf) begin
      res_d = {s2_q.sx, {(W-1){1'b0}}};
      flg_d = 4'b0011;
    end else if (ovf) begin
      res_d = {s2_q.sx, EMAX, {MAN_W{1'b0}}};
      flg_d = 4'b0101;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      s1_q  <= '0;
      s2_q  <= '0;
      vld_q <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
    end else if (!stall) begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      vld_q <= vld_d;
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: exact-arithmetic reference model,
// directed corner cases, stall, reset and random streaming.
module tb_fp_addsub_pipe;

  logic        clk;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Reference: exact sum as a wide integer in units of 2^-149,
  // then IEEE round-to-nearest-even. Returns {flags, result}.
  function automatic logic [35:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic o);
    logic sa, sb, sr, up;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic [299:0] va, vb, mag, rem, half, one;
    logic [24:0] kept;
    int p, sh, be;
    sa = a[31]; sb = b[31] ^ o;
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0]; fb = b[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0))
      return {4'b1000, 32'h7FC00000};
    if (ea == 8'hFF && eb == 8'hFF)
      return (sa != sb) ? {4'b1000, 32'h7FC00000}
                        : {4'b0000, sa, 8'hFF, 23'h0};
    if (ea == 8'hFF) return {4'b0000, sa, 8'hFF, 23'h0};
    if (eb == 8'hFF) return {4'b0000, sb, 8'hFF, 23'h0};
    if (ea == 0 && eb == 0) return {4'b0000, sa & sb, 31'h0};
    one = 1;
    va = (ea == 0) ? '0 : {276'h0, 1'b1, fa} << (int'(ea) - 1);
    vb = (eb == 0) ? '0 : {276'h0, 1'b1, fb} << (int'(eb) - 1);
    if (sa == sb) begin mag = va + vb; sr = sa; end
    else if (va >= vb) begin mag = va - vb; sr = sa; end
    else begin mag = vb - va; sr = sb; end
    if (mag == 0) return 36'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    be = p - 22;
    if (be <= 0) return {4'b0011, sr, 31'h0};
    sh   = p - 23;
    kept = 25'(mag >> sh);
    rem  = mag & ((one << sh) - one);
    half = (sh > 0) ? (one << (sh - 1)) : '0;
    up   = (sh > 0) && (rem > half || (rem == half && kept[0]));
    kept = kept + 25'(up);
    if (kept[24]) begin kept = kept >> 1; be++; end
    if (be >= 255) return {4'b0101, sr, 8'hFF, 23'h0};
    return {3'b000, rem != 0, sr, 8'(be), kept[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op(input logic [31:0] rf);
    logic [31:0] r;
    int e;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: case ($urandom_range(0, 5))
           0: r = 32'h00000000;
           1: r = 32'h80000000;
           2: r = 32'h7F800000;
           3: r = 32'hFF800000;
           4: r = 32'h7FA00000;
           default: r = {r[31], 8'h00, r[22:0]};
         endcase
      1: r = {r[31], rf[30:23], r[22:0]};
      2: r = {r[31], rf[30:4], r[3:0]};
      3: r = {r[31], 8'($urandom_range(250, 254)), r[22:0]};
      4: r = {r[31], 8'($urandom_range(1, 4)), r[22:0]};
      5: begin
        e = int'(rf[30:23]) - int'($urandom_range(0, 30));
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        r = {r[31], 8'(e), r[22:0]};
      end
      default: r = {r[31], 8'($urandom_range(1, 254)), r[22:0]};
    endcase
    return r;
  endfunction

  logic        held = 1'b0;
  logic [31:0] hres;
  logic [3:0]  hflg;

  always @(negedge clk) begin
    logic [35:0] e;
    if (!RST) begin
      held = 1'b0;
    end else begin
      if (held)
        chk("hold", {out_valid, flags, result}, {1'b1, hflg, hres});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop: output %h with nothing expected", result);
        end else begin
          e = exp_q.pop_front();
          chk("stream", {flags, result}, e);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(A, B, op));
      held = out_valid && !out_ready;
      hres = result;
      hflg = flags;
    end
  end

  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         input logic o, input logic [35:0] ev);
    int n;
    logic got;
    in_valid = 1'b1; A = a; B = b; op = o; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1; got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) got = 1'b1;
    end
    chk("latency", 64'(n), 64'd3);
    if (got) chk("directed", {flags, result}, ev);
  endtask

  logic [31:0] da[8], db[8];
  logic        dop[8];
  logic [35:0] dexp[8];
  logic [31:0] sa6[6], sb6[6];

  initial begin
    da[0] = 32'h40400000; db[0] = 32'h3F800000; dop[0] = 1;
    dexp[0] = {4'b0000, 32'h40000000};
    da[1] = 32'h3F800000; db[1] = 32'h3F800000; dop[1] = 0;
    dexp[1] = {4'b0000, 32'h40000000};
    da[2] = 32'h3F800000; db[2] = 32'h3F800000; dop[2] = 1;
    dexp[2] = {4'b0000, 32'h00000000};
    da[3] = 32'h3F800000; db[3] = 32'h33800000; dop[3] = 0;
    dexp[3] = {4'b0001, 32'h3F800000};
    da[4] = 32'h7F800000; db[4] = 32'h7F800000; dop[4] = 1;
    dexp[4] = {4'b1000, 32'h7FC00000};
    da[5] = 32'h7F7FFFFF; db[5] = 32'h7F7FFFFF; dop[5] = 0;
    dexp[5] = {4'b0101, 32'h7F800000};
    da[6] = 32'h00800001; db[6] = 32'h00800000; dop[6] = 1;
    dexp[6] = {4'b0011, 32'h00000000};
    da[7] = 32'h3F800000; db[7] = 32'h33C00000; dop[7] = 0;
    dexp[7] = {4'b0001, 32'h3F800001};

    RST = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 1'b0; A = '0; B = '0;
    #12;
    chk("reset", {out_valid, flags, result}, 64'd0);
    RST = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      chk("model_pin", model(da[i], db[i], dop[i]), dexp[i]);
      run_one(da[i], db[i], dop[i], dexp[i]);
    end

    // back-to-back stream with consumer stalling in cycles 4..6
    for (int i = 0; i < 6; i++) begin
      sa6[i] = rnd_op($urandom);
      sb6[i] = rnd_op(sa6[i]);
    end
    begin
      int i, cyc;
      @(posedge clk); #1;
      i = 0; cyc = 0;
      while (i < 6 && cyc < 40) begin
        in_valid = 1'b1; A = sa6[i]; B = sb6[i]; op = i[0];
        out_ready = !(cyc >= 4 && cyc <= 6);
        @(negedge clk);
        if (cyc >= 4 && cyc <= 6)
          chk("stall_rdy", {out_valid, in_ready}, 64'b10);
        if (in_ready) i++;
        @(posedge clk); #1;
        cyc++;
      end
      chk("stall_sent", 64'(i), 64'd6);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("stall_drain", 64'(exp_q.size()), 64'd0);
    end

    // random streaming with random back-pressure
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 1);
      A  = rnd_op($urandom);
      B  = rnd_op(A);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rand_drain", 64'(exp_q.size()), 64'd0);

    // asynchronous reset with ops in flight
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      A = rnd_op($urandom); B = rnd_op(A); op = c[0];
      @(posedge clk); #1;
    end
    #2;
    RST = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid", {out_valid, flags, result}, 64'd0);
    @(posedge clk); #3;
    RST = 1'b1;
    @(posedge clk); #1;
    chk("rst_empty", 64'(out_valid), 64'd0);
    run_one(da[0], db[0], dop[0], dexp[0]);
    @(posedge clk); #1;
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
